// File: rtl/ejtag_ir_unit_pkg.sv
// Shared EJTAG instruction-register constants: 5-bit opcodes, select codes
// and the capture pattern loaded into the shift stage.
package ejtag_ir_unit_pkg;

    // Opcodes are defined on 5 bits and zero-extended to IR_WIDTH.
    localparam logic [4:0] ETAP_IDCODE     = 5'h01;
    localparam logic [4:0] SAMPLE_PRELOAD  = 5'h02;
    localparam logic [4:0] ETAP_IMPCODE    = 5'h03;
    localparam logic [4:0] ETAP_ADDRESS    = 5'h08;
    localparam logic [4:0] ETAP_DATA       = 5'h09;
    localparam logic [4:0] ETAP_CONTROL    = 5'h0A;
    localparam logic [4:0] ETAP_ALL        = 5'h0B;
    localparam logic [4:0] ETAP_EJTAGBOOT  = 5'h0C;
    localparam logic [4:0] ETAP_NORMALBOOT = 5'h0D;
    localparam logic [4:0] ETAP_FASTDATA   = 5'h0E;
    localparam logic [4:0] BYPASS          = 5'h1F;

    // Data-register select codes seen by the DR mux.
    typedef enum logic [3:0] {
        SEL_IDCODE         = 4'd0,
        SEL_IMPCODE        = 4'd1,
        SEL_ADDRESS        = 4'd2,
        SEL_DATA           = 4'd3,
        SEL_CONTROL        = 4'd4,
        SEL_EJTAGBOOT      = 4'd5,
        SEL_BYPASS         = 4'd6,
        SEL_SAMPLE_PRELOAD = 4'd7,
        SEL_ALL            = 4'd8,
        SEL_NORMALBOOT     = 4'd9,
        SEL_FASTDATA       = 4'd10
    } sel_e;

    // IEEE 1149.1 mandates ...01 in the two LSBs captured into the IR.
    localparam logic [1:0] CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/ejtag_ir_decode.sv
// Pure combinational opcode -> select decode; every unmapped value,
// including any nonzero bit above bit 4, selects BYPASS.
module ejtag_ir_decode
    import ejtag_ir_unit_pkg::*;
#(
    parameter int unsigned IR_WIDTH  = 5,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic [IR_WIDTH-1:0]  i_opcode,
    output logic [SEL_WIDTH-1:0] o_sel
);

    // Widen to at least 5 bits so narrow IRs still match zero-extended opcodes.
    localparam int unsigned EXT_WIDTH = (IR_WIDTH > 5) ? IR_WIDTH : 5;

    logic [EXT_WIDTH-1:0] w_ext;
    sel_e                 w_code;

    assign w_ext = EXT_WIDTH'(i_opcode);

    // Full-value match with a BYPASS default.
    always_comb begin
        w_code = SEL_BYPASS;
        if ((w_ext >> 5) == '0) begin
            case (w_ext[4:0])
                ETAP_IDCODE:     w_code = SEL_IDCODE;
                ETAP_IMPCODE:    w_code = SEL_IMPCODE;
                ETAP_ADDRESS:    w_code = SEL_ADDRESS;
                ETAP_DATA:       w_code = SEL_DATA;
                ETAP_CONTROL:    w_code = SEL_CONTROL;
                ETAP_EJTAGBOOT:  w_code = SEL_EJTAGBOOT;
                BYPASS:          w_code = SEL_BYPASS;
                SAMPLE_PRELOAD:  w_code = SEL_SAMPLE_PRELOAD;
                ETAP_ALL:        w_code = SEL_ALL;
                ETAP_NORMALBOOT: w_code = SEL_NORMALBOOT;
                ETAP_FASTDATA:   w_code = SEL_FASTDATA;
                default:         w_code = SEL_BYPASS;
            endcase
        end
    end

    assign o_sel = SEL_WIDTH'(w_code);

endmodule

// File: rtl/ejtag_ir_unit.sv
// EJTAG instruction-register unit: IR shift stage, latched instruction,
// registered select decode and sticky EJTAGBOOT flag.
module ejtag_ir_unit
    import ejtag_ir_unit_pkg::*;
#(
    parameter int unsigned IR_WIDTH  = 5,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic                 tck,
    input  logic                 trst_n,
    input  logic                 tap_reset,
    input  logic                 capture_ir,
    input  logic                 shift_ir,
    input  logic                 update_ir,
    input  logic                 tdi,
    output logic                 ir_tdo,
    output logic [IR_WIDTH-1:0]  ir,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 ejtagboot
);

    localparam logic [IR_WIDTH-1:0]  CAPTURE_VAL = IR_WIDTH'(CAPTURE_LSBS);
    localparam logic [IR_WIDTH-1:0]  IDCODE_VAL  = IR_WIDTH'(ETAP_IDCODE);
    localparam logic [SEL_WIDTH-1:0] SEL_ID_VAL  = SEL_WIDTH'(SEL_IDCODE);
    localparam logic [SEL_WIDTH-1:0] SEL_EB_VAL  = SEL_WIDTH'(SEL_EJTAGBOOT);
    localparam logic [SEL_WIDTH-1:0] SEL_NB_VAL  = SEL_WIDTH'(SEL_NORMALBOOT);

    logic [IR_WIDTH-1:0]  r_ir_sr;
    logic [IR_WIDTH-1:0]  r_ir;
    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_boot;
    logic [SEL_WIDTH-1:0] w_sel;

    // Decode sits on the shift stage so sel is registered alongside ir.
    ejtag_ir_decode #(
        .IR_WIDTH  (IR_WIDTH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_decode (
        .i_opcode (r_ir_sr),
        .o_sel    (w_sel)
    );

    // Shift stage: reset/capture load the IEEE pattern, shift is LSB first.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_sr <= CAPTURE_VAL;
        end else if (tap_reset) begin
            r_ir_sr <= CAPTURE_VAL;
        end else if (update_ir) begin
            r_ir_sr <= r_ir_sr;
        end else if (capture_ir) begin
            r_ir_sr <= CAPTURE_VAL;
        end else if (shift_ir) begin
            r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Latched instruction and select change only on reset or update.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir  <= IDCODE_VAL;
            r_sel <= SEL_ID_VAL;
        end else if (tap_reset) begin
            r_ir  <= IDCODE_VAL;
            r_sel <= SEL_ID_VAL;
        end else if (update_ir) begin
            r_ir  <= r_ir_sr;
            r_sel <= w_sel;
        end
    end

    // Sticky boot request survives tap_reset; only trst_n or NORMALBOOT clear it.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_boot <= 1'b0;
        end else if (!tap_reset && update_ir) begin
            if (w_sel == SEL_EB_VAL) begin
                r_boot <= 1'b1;
            end else if (w_sel == SEL_NB_VAL) begin
                r_boot <= 1'b0;
            end
        end
    end

    assign ir_tdo    = r_ir_sr[0];
    assign ir        = r_ir;
    assign sel       = r_sel;
    assign ejtagboot = r_boot;

endmodule
